position_arbiter: RTL and testbench

POSITION_ARBITER -- requirements
Module: position_arbiter

---
 rtl/position_arbiter_pkg.sv | 35 +++
 rtl/position_arbiter_decoder.sv | 19 +
 rtl/position_arbiter.sv | 84 ++++++++
 tb/tb_position_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/position_arbiter_pkg.sv
// Shared types and sizes for the position arbiter.
// Includes the round-robin search helper used on grant.
package position_arbiter_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // First set request at or above ptr, wrapping past the top index.
    function automatic logic [IDX_W-1:0] first_req(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] j;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = ptr + IDX_W'(k);
            if (!found && req[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/position_arbiter_decoder.sv
// One-hot decoder of the grant index.
// Output is all zero while enable is low.
module position_decoder
    import position_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   in,
    input  logic               enable,
    output logic [NUM_REQ-1:0] out
);

    // Single bit set at position in, only when enabled.
    always_comb begin
        out = '0;
        if (enable) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/position_arbiter.sv
// Round-robin arbiter for the shared position resource.
// Grants are held until done, abandon or hold timeout.
module position_arbiter
    import position_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               timeout
);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold;
    logic              hold_hit;
    logic              leave;

    assign hold_hit    = (hold == HOLD_W'(HOLD_MAX - 1));
    assign grant_valid = (state == GRANT);

    // Next state and the grant-exit condition.
    always_comb begin
        state_nxt = state;
        leave     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (done || !req[grant_idx] || hold_hit) begin
                    state_nxt = RELEASE;
                    leave     = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, grant index, hold counter and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            hold      <= '0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_nxt;
            timeout <= leave && hold_hit && !done;
            if (state == IDLE && |req) begin
                grant_idx <= first_req(req, ptr);
                hold      <= '0;
            end
            if (state == GRANT) begin
                if (leave) begin
                    ptr <= grant_idx + 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    position_decoder u_dec (
        .in     (grant_idx),
        .enable (grant_valid),
        .out    (grant_onehot)
    );

endmodule

// File: tb/tb_position_arbiter.sv
// Self-checking bench for position_arbiter.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_position_arbiter;

    localparam int HM = 4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic [15:0] grant_onehot;
    logic        timeout;

    int vectors;
    int miscompares;

    // Reference model: integer bookkeeping of who holds the resource.
    bit m_busy;
    bit m_rel;
    bit m_to;
    int m_idx;
    int m_ptr;
    int m_hold;

    position_arbiter #(.HOLD_MAX(HM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_rel  = 0;
        m_to   = 0;
        m_idx  = 0;
        m_ptr  = 0;
        m_hold = 0;
    endtask

    task automatic model_edge();
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_rel) begin
            m_rel = 0;
            m_to  = 0;
        end else if (m_busy) begin
            hit = (m_hold == HM - 1);
            if (done || !req[m_idx] || hit) begin
                m_busy = 0;
                m_rel  = 1;
                m_to   = hit && !done;
                m_ptr  = (m_idx + 1) % 16;
            end else begin
                m_hold++;
            end
        end else if (req != 0) begin
            for (int k = 0; k < 16; k++) begin
                if (!m_busy && req[(m_ptr + k) % 16]) begin
                    m_idx  = (m_ptr + k) % 16;
                    m_busy = 1;
                    m_hold = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] oh;
        oh = m_busy ? (16'h1 << m_idx) : 16'h0;
        chk("grant_valid", {15'h0, grant_valid}, {15'h0, m_busy});
        chk("grant_idx", {12'h0, grant_idx}, 16'(m_idx));
        chk("grant_onehot", grant_onehot, oh);
        chk("timeout", {15'h0, timeout}, {15'h0, m_to});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single requester 0, then done.
        req = 16'h0001;
        step();
        chk("first_idx0", {12'h0, grant_idx}, 16'h0);
        chk("first_oh", grant_onehot, 16'h0001);
        done = 1'b1;
        step();
        chk("release_gv", {15'h0, grant_valid}, 16'h0);
        done = 1'b0;
        req  = '0;
        step();

        // Alternation between 0 and 15 with done every grant.
        req  = 16'h8001;
        done = 1'b1;
        repeat (12) step();
        done = 1'b0;
        req  = '0;
        repeat (2) step();

        // Move pointer to 14, then wrap-around search.
        req = 16'h2000;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = '0;
        step();
        req = 16'h0009;
        step();
        chk("wrap_idx0", {12'h0, grant_idx}, 16'h0);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        chk("next_idx3", {12'h0, grant_idx}, 16'h3);
        req = '0;
        repeat (3) step();

        // Forced release after HM cycles.
        req = 16'h0020;
        repeat (HM) step();
        chk("hold_last_gv", {15'h0, grant_valid}, 16'h1);
        step();
        chk("timeout_pulse", {15'h0, timeout}, 16'h1);
        req = '0;
        step();
        chk("timeout_gone", {15'h0, timeout}, 16'h0);

        // Abandon: drop req[2] mid-grant.
        req = 16'h0004;
        step();
        step();
        req = 16'h0000;
        step();
        chk("abandon_to", {15'h0, timeout}, 16'h0);
        step();

        // Done coinciding with the last hold cycle.
        req = 16'h0004;
        repeat (HM) step();
        done = 1'b1;
        step();
        chk("done_vs_to", {15'h0, timeout}, 16'h0);
        done = 1'b0;
        req  = '0;
        step();

        // Asynchronous reset between edges during a grant.
        req = 16'h0010;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_gv", {15'h0, grant_valid}, 16'h0);
        chk("async_oh", grant_onehot, 16'h0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("after_rst_idx4", {12'h0, grant_idx}, 16'h4);
        req = '0;
        repeat (3) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req  = 16'($urandom) & 16'($urandom) & 16'($urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
